// File: rtl/mdu_unit_pkg.sv
// mdu_defs: shared definitions for the multiply/divide unit.
//   - mdu_op encodings (4 bit)
//   - multi-cycle op set and predicates is_mc() / is_div()
//   - mdu_res_t: calc result bundle (64-bit {HI,LO} value + write enable)
//   - mdu_state_e: unit FSM states
// Optional feature: MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU to the
// multi-cycle set; with it undefined those codes decode as undefined.
package mdu_defs;

  localparam logic [3:0] MDU_MULT  = 4'd0;
  localparam logic [3:0] MDU_MULTU = 4'd1;
  localparam logic [3:0] MDU_DIV   = 4'd2;
  localparam logic [3:0] MDU_DIVU  = 4'd3;
  localparam logic [3:0] MDU_MTHI  = 4'd4;
  localparam logic [3:0] MDU_MTLO  = 4'd5;
  localparam logic [3:0] MDU_MADD  = 4'd6;
  localparam logic [3:0] MDU_MADDU = 4'd7;
  localparam logic [3:0] MDU_MSUB  = 4'd8;
  localparam logic [3:0] MDU_MSUBU = 4'd9;

  // One bit per opcode: set where the op enters BUSY and writes through
  // the pending register.
`ifdef MDU_MADD_EN
  localparam logic [15:0] MDU_MC_SET = 16'h03CF;
`else
  localparam logic [15:0] MDU_MC_SET = 16'h000F;
`endif

  typedef enum logic {S_IDLE, S_BUSY} mdu_state_e;

  typedef struct packed {
    logic [63:0] val;  // {HI,LO}
    logic        we;   // low on divide by zero / non multi-cycle op
  } mdu_res_t;

  function automatic logic is_mc(input logic [3:0] op);
    return MDU_MC_SET[op];
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_unit_if.sv
// mdu_unit_if: Execute-stage handshake between issue logic and the MDU.
//   start  : one-cycle issue strobe
//   mdu_op : operation code (mdu_defs constants)
//   srcA/B : rs / rt operands
//   busy   : operation in progress (registered)
//   hi_out/lo_out : architectural HI/LO
// master = issuing side, slave = mdu_unit.
interface mdu_unit_if;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        busy;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  modport master (output start, mdu_op, srcA, srcB,
                  input  busy, hi_out, lo_out);
  modport slave  (input  start, mdu_op, srcA, srcB,
                  output busy, hi_out, lo_out);
endinterface

// File: rtl/mdu_unit_calc.sv
// mdu_calc: purely combinational MDU datapath.
//   op, srca, srcb : operation and operands
//   hi_in, lo_in   : current HI/LO (accumulate ops only)
//   res            : 64-bit {HI,LO} result + write enable
// Signed divide is done on magnitudes and sign-fixed afterwards, which
// also yields the 0x80000000 / -1 overflow result (LO=0x80000000, HI=0).
// With MDU_MADD_EN undefined no accumulator adder exists.
module mdu_calc
  import mdu_defs::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  output mdu_res_t    res
);

  logic [63:0] prod_s, prod_u;
  logic        dsgn, dzero;
  logic [31:0] dvd, dvs, dvs_safe, quo, rem, quo_fix, rem_fix;

  // Low 64 bits of a 64x64 product of sign-extended operands is the
  // exact signed 32x32 product.
  assign prod_s = {{32{srca[31]}}, srca} * {{32{srcb[31]}}, srcb};
  assign prod_u = {32'b0, srca} * {32'b0, srcb};

  assign dsgn     = (op == MDU_DIV);
  assign dzero    = (srcb == 32'd0);
  assign dvd      = (dsgn && srca[31]) ? -srca : srca;
  assign dvs      = (dsgn && srcb[31]) ? -srcb : srcb;
  // Keep the divider defined on zero; the result is discarded anyway.
  assign dvs_safe = dzero ? 32'd1 : dvs;
  assign quo      = dvd / dvs_safe;
  assign rem      = dvd % dvs_safe;
  assign quo_fix  = (dsgn && (srca[31] ^ srcb[31])) ? -quo : quo;
  assign rem_fix  = (dsgn && srca[31]) ? -rem : rem;

`ifdef MDU_MADD_EN
  logic [63:0] acc, acc_prod;
  logic        acc_sub;
  assign acc      = {hi_in, lo_in};
  assign acc_sub  = (op == MDU_MSUB) || (op == MDU_MSUBU);
  assign acc_prod = ((op == MDU_MADD) || (op == MDU_MSUB)) ? prod_s : prod_u;
`else
  logic unused_acc;
  assign unused_acc = ^{hi_in, lo_in};
`endif

  always_comb begin
    res.val = 64'd0;
    res.we  = 1'b0;
    case (op)
      MDU_MULT:  begin res.val = prod_s; res.we = 1'b1; end
      MDU_MULTU: begin res.val = prod_u; res.we = 1'b1; end
      MDU_DIV:   begin res.val = {rem_fix, quo_fix}; res.we = !dzero; end
      MDU_DIVU:  begin res.val = {rem, quo};         res.we = !dzero; end
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: begin
        res.val = acc_sub ? (acc - acc_prod) : (acc + acc_prod);
        res.we  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: Execute-stage multiply/divide unit holding HI/LO.
//   clk, reset_n : clock, async active-low reset
//   mdu (slave)  : start/mdu_op/srcA/srcB in; busy/hi_out/lo_out out
// Multi-cycle ops compute at issue into a pending register, then count
// MULT_CYCLES or DIV_CYCLES busy cycles before committing to HI/LO.
// MTHI/MTLO write immediately. Start while busy and undefined ops are
// ignored. Optional feature macro: MDU_MADD_EN (accumulate ops).
module mdu_unit
  import mdu_defs::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
)(
  input  logic clk,
  input  logic reset_n,
  mdu_unit_if.slave mdu
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  mdu_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0] pend_q, pend_d;
  logic        pend_we_q, pend_we_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  mdu_res_t    calc_res;

  mdu_calc u_calc (
    .op    (mdu.mdu_op),
    .srca  (mdu.srcA),
    .srcb  (mdu.srcB),
    .hi_in (hi_q),
    .lo_in (lo_q),
    .res   (calc_res)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pend_q    <= '0;
      pend_we_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_we_q <= pend_we_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pend_we_d = pend_we_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      S_IDLE: begin
        if (mdu.start) begin
          if (is_mc(mdu.mdu_op)) begin
            pend_d    = calc_res.val;
            pend_we_d = calc_res.we;
            cnt_d     = is_div(mdu.mdu_op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            state_d   = S_BUSY;
          end else if (mdu.mdu_op == MDU_MTHI) begin
            hi_d = mdu.srcA;
          end else if (mdu.mdu_op == MDU_MTLO) begin
            lo_d = mdu.srcA;
          end
        end
      end
      S_BUSY: begin
        // start is ignored here; last busy cycle commits the result.
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          if (pend_we_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mdu.busy   = (state_q == S_BUSY);
  assign mdu.hi_out = hi_q;
  assign mdu.lo_out = lo_q;

  // The hazard unit stalls issue on (start | busy).
  a_no_start_busy: assert property (@(posedge clk) disable iff (!reset_n)
                                    !(mdu.start && state_q == S_BUSY));

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multiply/divide unit in the Execute stage, beside the ALU.
- Takes the same srcA/srcB operands the ALU receives.
- Holds the HI/LO architectural registers and runs mult/multu/div/divu with a fixed multi-cycle latency.
- Its busy/start outputs drive the hazard unit's stall of mfhi/mflo/mult-class instructions in D stage.

Parameters:
- MULT_CYCLES, 5, busy cycles after a multiply start (>=1)
- DIV_CYCLES, 10, busy cycles after a divide start (>=1)

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle strobe: issue mdu_op this cycle
- mdu_op  in  4  operation code (package constants)
- srcA  in  32  rs operand
- srcB  in  32  rt operand
- busy  out  1  operation in progress
- hi_out  out  32  architectural HI
- lo_out  out  32  architectural LO

Behaviour:
- Reset:
  - reset_n low asynchronously clears hi_out, lo_out, busy, counter, pending result and state to IDLE.
  - This holds mid-operation; the in-flight result is discarded.
- States: IDLE, BUSY.
- Multiply/divide issue:
  - In IDLE, start=1 with mdu_op in {MULT,MULTU,DIV,DIVU} latches the 64-bit result into a pending register at edge t.
  - Counter is loaded with MULT_CYCLES or DIV_CYCLES; go to BUSY.
  - busy=1 for cycles t+1 .. t+N; counter decrements each cycle.
  - On the edge where the counter reaches 1, hi_out/lo_out take the pending value and busy falls. New values are visible from cycle t+N+1.
- Move-to ops:
  - start=1 with MTHI/MTLO in IDLE writes srcA to HI/LO at that edge.
  - busy stays 0; the other register is unchanged.
- Ignored inputs:
  - start while BUSY is ignored entirely; the hazard unit guarantees this never happens, and the assertion checks it.
  - Undefined mdu_op is ignored.
- Arithmetic:
  - MULT: signed 32x32 -> 64; HI = [63:32], LO = [31:0].
  - MULTU: same as MULT, unsigned.
  - DIV: signed; LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIV overflow: 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
  - DIVU: unsigned quotient and remainder.
- Divide by zero (srcB = 0):
  - Full DIV_CYCLES busy period still runs.
  - HI/LO remain unchanged at completion.
- busy is a registered output; no combinational path from inputs.
- The hazard unit uses (start | busy) for stalling. This block does not generate start-based stall itself.

Optional Feature:
- Macro MDU_MADD_EN.
- When defined:
  - Adds MADD, MADDU, MSUB, MSUBU.
  - At issue, the pending value = {HI,LO} ± product, using HI/LO as they are at the issue edge. The product is signed for MADD/MSUB and unsigned for MADDU/MSUBU.
  - Latency is MULT_CYCLES.
- When undefined:
  - These codes are treated as undefined and ignored.
  - No accumulator adder is synthesised.

Decomposition:
- Shared package mdu_defs holds the mdu_op constants: MDU_MULT=0, MDU_MULTU=1, MDU_DIV=2, MDU_DIVU=3, MDU_MTHI=4, MDU_MTLO=5, MDU_MADD=6, MDU_MADDU=7, MDU_MSUB=8, MDU_MSUBU=9.
- It also holds a helper predicate constant set: "is multi-cycle op".
- Natural sub-module: mdu_calc. It is purely combinational: op, srcA, srcB, current HI/LO -> 64-bit result plus a write-enable (deasserted on divide by zero).
- mdu_unit keeps the state machine, counter and registers.

Test Plan:
- MULT, srcA=0xFFFFFFFF, srcB=2, start at t -> busy high t+1..t+5, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- MULTU, same operands -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- DIV, srcA=0xFFFFFFF9 (-7), srcB=2 -> 10 busy cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- MTHI 0x12345678 then DIVU 7/0:
  - HI=0x12345678 next cycle with busy=0.
  - DIVU runs 10 busy cycles, then HI/LO are unchanged.
- reset_n pulsed low at cycle t+3 of a DIV -> busy, HI, LO = 0 immediately (asynchronous). A new MULT issued after release completes normally.
- With MDU_MADD_EN: preload HI=0, LO=0xFFFFFFFF, then MADDU 1*1 -> HI=1, LO=0 after 5 cycles. Without the macro, the same code leaves HI/LO unchanged and busy=0.
